game_flow_ctrl: RTL and testbench

//  Top-level game sequencer for the plane shooter: start screen -> play -> boss -> game over.

---
 rtl/game_pkg.sv | 18 +
 rtl/bcd_score_acc.sv | 51 +++++
 rtl/game_flow_ctrl.sv | 148 ++++++++++++++
 tb/tb_game_flow_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and widths for the game sequencer: FSM state encoding and
// score/level sizing used by the top and the BCD score accumulator.
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_PLAY  = 3'd2,
        ST_BOSS  = 3'd3,
        ST_OVER  = 3'd4
    } game_state_e;

    localparam int SCORE_DIGITS = 4;
    localparam int SCORE_W      = 4 * SCORE_DIGITS;
    localparam int LEVEL_W      = 3;
    localparam int STATE_W      = 3;

endpackage

// File: rtl/bcd_score_acc.sv
// Four-digit saturating BCD accumulator: adds 1 to units or 1 to tens per
// cycle, clears on request, and pins at 9999 instead of wrapping.
module bcd_score_acc
    import game_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               inc1,
    input  logic               inc10,
    output logic [SCORE_W-1:0] score
);

    logic [3:0] digit_reg [SCORE_DIGITS];
    logic [3:0] digit_sum [SCORE_DIGITS];
    logic [3:0] add_bit;
    logic       carry_out;

    assign add_bit = {2'b00, inc10, inc1};

    // Ripple the decimal carry through the digits in one pass.
    always_comb begin
        logic       c;
        logic [4:0] raw;
        c   = 1'b0;
        raw = '0;
        for (int i = 0; i < SCORE_DIGITS; i++) begin
            raw          = 5'(digit_reg[i]) + 5'(add_bit[i]) + 5'(c);
            c            = (raw >= 5'd10);
            digit_sum[i] = c ? 4'(raw - 5'd10) : raw[3:0];
        end
        carry_out = c;
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            for (int i = 0; i < SCORE_DIGITS; i++) digit_reg[i] <= 4'd0;
        end else if (carry_out) begin
            for (int i = 0; i < SCORE_DIGITS; i++) digit_reg[i] <= 4'd9;
        end else if (inc1 || inc10) begin
            for (int i = 0; i < SCORE_DIGITS; i++) digit_reg[i] <= digit_sum[i];
        end
    end

    generate
        for (genvar gi = 0; gi < SCORE_DIGITS; gi++) begin : g_score_out
            assign score[gi*4 +: 4] = digit_reg[gi];
        end
    endgenerate

endmodule

// File: rtl/game_flow_ctrl.sv
// Game sequencer: IDLE -> START (restart pulse) -> PLAY <-> BOSS -> OVER,
// with edge-detected keyboard/boom inputs, BCD score and saturating level.
module game_flow_ctrl
    import game_pkg::*;
#(
    parameter int BOSS_KILLS  = 10,
    parameter int RST_CYCLES  = 4,
    parameter int OVER_FRAMES = 180,
    parameter int MAX_LEVEL   = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enter,
    input  logic               frame_tick,
    input  logic [3:0]         present_health,
    input  logic               enemy_boom,
    input  logic               boss_boom,
    output logic               play_en,
    output logic               end_en,
    output logic               boss_spawn,
    output logic               game_rst,
    output logic [SCORE_W-1:0] score,
    output logic [LEVEL_W-1:0] level,
    output logic [STATE_W-1:0] state
);

    localparam int RST_W  = $clog2(RST_CYCLES + 1);
    localparam int KILL_W = $clog2(BOSS_KILLS + 1);
    localparam int OVER_W = $clog2(OVER_FRAMES + 1);

    game_state_e        state_reg, state_next;
    logic               enter_prev_reg, enemy_prev_reg, boss_prev_reg;
    logic [RST_W-1:0]   rst_cnt_reg;
    logic [KILL_W-1:0]  kill_cnt_reg;
    logic [OVER_W-1:0]  over_cnt_reg;
    logic [LEVEL_W-1:0] level_reg;
    logic               play_en_reg, end_en_reg, boss_spawn_reg, game_rst_reg;

    logic enter_rise, enemy_rise, boss_rise, health_zero;
    logic rst_done, boss_due, over_ready;
    logic score_clr, score_inc1, score_inc10;

    assign enter_rise  = enter & ~enter_prev_reg;
    assign enemy_rise  = enemy_boom & ~enemy_prev_reg;
    assign boss_rise   = boss_boom & ~boss_prev_reg;
    assign health_zero = (present_health == 4'd0);

    assign rst_done   = (rst_cnt_reg == RST_W'(RST_CYCLES - 1));
    assign boss_due   = enemy_rise && (kill_cnt_reg == KILL_W'(BOSS_KILLS - 1));
    assign over_ready = (over_cnt_reg == OVER_W'(OVER_FRAMES));

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (enter_rise) state_next = ST_START;
            ST_START: if (rst_done) state_next = ST_PLAY;
            ST_PLAY: begin
                // Player death wins over reaching the boss threshold.
                if (health_zero)   state_next = ST_OVER;
                else if (boss_due) state_next = ST_BOSS;
            end
            ST_BOSS: begin
                if (health_zero)    state_next = ST_OVER;
                else if (boss_rise) state_next = ST_PLAY;
            end
            ST_OVER:  if (enter_rise && over_ready) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    assign score_clr   = (state_reg == ST_IDLE) && enter_rise;
    assign score_inc1  = (state_reg == ST_PLAY) && enemy_rise;
    assign score_inc10 = (state_reg == ST_BOSS) && boss_rise;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            enter_prev_reg <= 1'b0;
            enemy_prev_reg <= 1'b0;
            boss_prev_reg  <= 1'b0;
            rst_cnt_reg    <= '0;
            kill_cnt_reg   <= '0;
            over_cnt_reg   <= '0;
            level_reg      <= LEVEL_W'(1);
            play_en_reg    <= 1'b0;
            end_en_reg     <= 1'b0;
            boss_spawn_reg <= 1'b0;
            game_rst_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            enter_prev_reg <= enter;
            enemy_prev_reg <= enemy_boom;
            boss_prev_reg  <= boss_boom;

            // Outputs follow the state being entered so they line up with state_reg.
            play_en_reg    <= (state_next == ST_START) || (state_next == ST_PLAY) ||
                              (state_next == ST_BOSS);
            end_en_reg     <= (state_next == ST_OVER);
            boss_spawn_reg <= (state_next == ST_BOSS);
            game_rst_reg   <= (state_next == ST_START);

            case (state_reg)
                ST_IDLE: begin
                    if (enter_rise) begin
                        level_reg    <= LEVEL_W'(1);
                        kill_cnt_reg <= '0;
                        rst_cnt_reg  <= '0;
                    end
                end
                ST_START: begin
                    rst_cnt_reg <= rst_done ? '0 : rst_cnt_reg + 1'b1;
                end
                ST_PLAY: begin
                    if (enemy_rise)
                        kill_cnt_reg <= boss_due ? '0 : kill_cnt_reg + 1'b1;
                end
                ST_BOSS: begin
                    if (boss_rise && !health_zero && (level_reg < LEVEL_W'(MAX_LEVEL)))
                        level_reg <= level_reg + 1'b1;
                end
                ST_OVER: begin
                    if (enter_rise && over_ready)
                        over_cnt_reg <= '0;
                    else if (frame_tick && !over_ready)
                        over_cnt_reg <= over_cnt_reg + 1'b1;
                end
                default: ;
            endcase
        end
    end

    bcd_score_acc u_score (
        .clk   (clk),
        .rst   (rst),
        .clr   (score_clr),
        .inc1  (score_inc1),
        .inc10 (score_inc10),
        .score (score)
    );

    assign play_en    = play_en_reg;
    assign end_en     = end_en_reg;
    assign boss_spawn = boss_spawn_reg;
    assign game_rst   = game_rst_reg;
    assign level      = level_reg;
    assign state      = state_reg;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Self-checking bench for game_flow_ctrl: directed game scenarios plus a long
// randomized play run, checked every cycle against an integer-level game model.
module tb_game_flow_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        enter, frame_tick, enemy_boom, boss_boom;
    logic [3:0]  present_health;
    logic        play_en, end_en, boss_spawn, game_rst;
    logic [15:0] score;
    logic [2:0]  level;
    logic [2:0]  state;

    game_flow_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .enter          (enter),
        .frame_tick     (frame_tick),
        .present_health (present_health),
        .enemy_boom     (enemy_boom),
        .boss_boom      (boss_boom),
        .play_en        (play_en),
        .end_en         (end_en),
        .boss_spawn     (boss_spawn),
        .game_rst       (game_rst),
        .score          (score),
        .level          (level),
        .state          (state)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Game model: phase 0 idle, 1 start, 2 play, 3 boss, 4 over.
    int m_phase, m_score, m_level, m_kills, m_rst_left, m_over;
    bit m_p_enter, m_p_enemy, m_p_boss;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit er, enr, br, hz;
        er  = enter && !m_p_enter;
        enr = enemy_boom && !m_p_enemy;
        br  = boss_boom && !m_p_boss;
        hz  = (present_health == 4'd0);
        if (rst) begin
            m_phase = 0; m_score = 0; m_level = 1; m_kills = 0; m_rst_left = 0; m_over = 0;
            m_p_enter = 0; m_p_enemy = 0; m_p_boss = 0;
            return;
        end
        case (m_phase)
            0: if (er) begin
                m_phase = 1; m_score = 0; m_level = 1; m_kills = 0; m_rst_left = 4;
            end
            1: begin
                m_rst_left--;
                if (m_rst_left == 0) m_phase = 2;
            end
            2: begin
                if (enr) begin
                    m_score = (m_score + 1 > 9999) ? 9999 : m_score + 1;
                    m_kills++;
                end
                if (hz) m_phase = 4;
                else if (m_kills == 10) begin m_phase = 3; m_kills = 0; end
            end
            3: begin
                if (br) m_score = (m_score + 10 > 9999) ? 9999 : m_score + 10;
                if (hz) m_phase = 4;
                else if (br) begin
                    m_level = (m_level + 1 > 7) ? 7 : m_level + 1;
                    m_phase = 2;
                end
            end
            default: begin
                if (er && m_over == 180) begin m_phase = 0; m_over = 0; end
                else if (frame_tick && m_over < 180) m_over++;
            end
        endcase
        m_p_enter = enter; m_p_enemy = enemy_boom; m_p_boss = boss_boom;
    endtask

    task automatic check_all();
        check("state", 16'(state), 16'(m_phase));
        check("play_en", 16'(play_en), 16'(m_phase >= 1 && m_phase <= 3));
        check("end_en", 16'(end_en), 16'(m_phase == 4));
        check("boss_spawn", 16'(boss_spawn), 16'(m_phase == 3));
        check("game_rst", 16'(game_rst), 16'(m_phase == 1));
        check("score", score, to_bcd(m_score));
        check("level", 16'(level), 16'(m_level));
    endtask

    task automatic step(input logic e, input logic t, input logic en, input logic b,
                        input logic [3:0] h);
        enter = e; frame_tick = t; enemy_boom = en; boss_boom = b; present_health = h;
        model_edge();
        @(posedge clk);
        #1;
        check_all();
        $display("[TB] t=%0t en=%0b tk=%0b eb=%0b bb=%0b hp=%0d -> st=%0d sc=%h lv=%0d rst=%0b",
                 $time, e, t, en, b, h, state, score, level, game_rst);
    endtask

    // One kill in whatever phase the game is in: enemy in PLAY, boss in BOSS.
    task automatic kill_pulse();
        if (m_phase == 2)      step(1'b0, 1'b0, 1'b1, 1'b0, 4'd15);
        else if (m_phase == 3) step(1'b0, 1'b0, 1'b0, 1'b1, 4'd15);
        else                   step(1'b0, 1'b0, 1'b0, 1'b0, 4'd15);
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'd15);
    endtask

    initial begin
        int rst_high;
        int cyc;
        rst = 1'b1;
        enter = 0; frame_tick = 0; enemy_boom = 0; boss_boom = 0; present_health = 4'd15;
        step(0, 0, 0, 0, 4'd15);
        step(0, 0, 0, 0, 4'd15);
        rst = 1'b0;
        step(0, 0, 0, 0, 4'd15);

        // Enter held for 5 cycles: exactly one START with a 4-cycle restart pulse.
        rst_high = 0;
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0, 0, 4'd15);
            if (i == 0) check("play_en_after_enter", 16'(play_en), 16'd1);
            rst_high += int'(game_rst);
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 4'd15);
            rst_high += int'(game_rst);
        end
        check("game_rst_len", 16'(rst_high), 16'd4);
        check("in_play", 16'(state), 16'd2);

        // Ten enemy kills -> boss phase.
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 1, 0, 4'd15);
            step(0, 0, 0, 0, 4'd15);
        end
        check("score_10", score, 16'h0010);
        check("boss_spawn_on", 16'(boss_spawn), 16'd1);

        // Enemy ignored in BOSS; boss kill adds ten and bumps the level.
        step(0, 0, 1, 0, 4'd15);
        step(0, 0, 0, 0, 4'd15);
        check("boss_enemy_ignored", score, 16'h0010);
        step(0, 0, 0, 1, 4'd15);
        step(0, 0, 0, 0, 4'd15);
        check("boss_kill_score", score, 16'h0020);
        check("boss_kill_level", 16'(level), 16'd2);

        // Kill and death in the same cycle.
        step(0, 0, 1, 0, 4'd0);
        check("death_score", score, 16'h0021);
        check("death_end_en", 16'(end_en), 16'd1);

        // Game-over hold-off: 179 ticks is not enough, 180 is.
        for (int i = 0; i < 179; i++) step(0, 1, 0, 0, 4'd15);
        step(1, 0, 0, 0, 4'd15);
        check("over_early_enter", 16'(state), 16'd4);
        step(0, 1, 0, 0, 4'd15);
        step(1, 0, 0, 0, 4'd15);
        check("over_to_idle", 16'(state), 16'd0);
        step(0, 0, 0, 0, 4'd15);
        step(1, 0, 0, 0, 4'd15);
        check("restart_score_clr", score, 16'h0000);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 4'd15);

        // Long randomized play toward the score ceiling.
        cyc = 0;
        while (m_score < 9990 && cyc < 60000) begin
            step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 4'($urandom_range(1, 15)));
            cyc++;
        end
        check("random_run_bound", 16'(cyc < 60000), 16'd1);
        step(0, 0, 0, 0, 4'd15);
        cyc = 0;
        while (m_score < 9998 && cyc < 2000) begin
            kill_pulse();
            cyc++;
        end
        for (int i = 0; i < 3; i++) kill_pulse();
        check("score_saturated", score, 16'h9999);

        // Boss kill at the top level keeps level at 7.
        cyc = 0;
        while (m_phase != 3 && cyc < 50) begin
            kill_pulse();
            cyc++;
        end
        check("reach_boss", 16'(state), 16'd3);
        kill_pulse();
        check("level_saturated", 16'(level), 16'd7);

        // Death, then a mid-game reset.
        step(0, 0, 0, 0, 4'd0);
        check("final_over", 16'(end_en), 16'd1);
        rst = 1'b1;
        step(0, 0, 0, 0, 4'd15);
        rst = 1'b0;
        check("reset_score", score, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
